// File: rtl/lock_sequencer.sv
// Four-digit keypad lock: buffers BCD digits, compares against CODE, then holds
// the servo latch open for a timed window or enforces a lockout after repeated failures.
module lock_sequencer #(
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int          UNLOCK_CYCLES  = 125_000_000,
    parameter int          LOCKOUT_CYCLES = 250_000_000,
    parameter int          MAX_FAILS      = 3
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Digit_Valid,
    input  logic [3:0] i_Digit,
    input  logic       i_Clear,
    output logic       o_Answer,
    output logic [2:0] o_Digit_Count,
    output logic [1:0] o_Fail_Count,
    output logic       o_Locked_Out,
    output logic [1:0] o_State
);

    localparam int MAX_CYC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]    FAIL_LIMIT   = 2'(MAX_FAILS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CHECK   = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   buf_q, buf_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          answer_q, answer_d;
    logic [1:0]    fail_inc;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= S_IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            fail_q   <= '0;
            timer_q  <= '0;
            answer_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
            answer_q <= answer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        timer_d  = timer_q;
        fail_inc = (fail_q >= FAIL_LIMIT) ? FAIL_LIMIT : fail_q + 2'd1;
        case (state_q)
            S_IDLE: begin
                // Clear takes priority over a digit strobed in the same cycle.
                if (i_Clear) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (i_Digit_Valid && (i_Digit <= 4'd9)) begin
                    buf_d = {buf_q[11:0], i_Digit};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if (buf_q == CODE) begin
                    state_d = S_OPEN;
                    fail_d  = '0;
                    timer_d = UNLOCK_LOAD;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == FAIL_LIMIT) begin
                        state_d = S_LOCKOUT;
                        timer_d = LOCKOUT_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_OPEN: begin
                if (i_Clear) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The latch output trails OPEN by one clock, but an early relock drops it on the same edge.
    always_comb begin
        answer_d     = (state_q == S_OPEN) && !i_Clear;
        o_Locked_Out = (state_q == S_LOCKOUT);
        o_State      = state_q;
    end

    assign o_Answer      = answer_q;
    assign o_Digit_Count = cnt_q;
    assign o_Fail_Count  = fail_q;

endmodule
